// File: rtl/console_tx_packer.sv
// console_tx_packer: drains the console_io output FIFO with GPIO read strobes and packs up to 4 chars per 32-bit word
// Optional feature: define CONSOLE_TX_PACKER_NL_FLUSH_EN to flush a partial word as soon as a newline (8'h0A) is captured.
module console_tx_packer #(
    parameter int READ_LATENCY  = 3,
    parameter int FLUSH_TIMEOUT = 1000,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] console_gpio_output,
    output logic        console_rd_strobe,
    output logic [31:0] word_data,
    output logic [2:0]  word_count,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy
);
`ifdef CONSOLE_TX_PACKER_NL_FLUSH_EN
    localparam logic NL_FLUSH = 1'b1;
`else
    localparam logic NL_FLUSH = 1'b0;
`endif
    localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY >= 2 ? READ_LATENCY - 2 : 0);
    localparam logic [TIMEOUT_WIDTH-1:0] IDLE_LAST = TIMEOUT_WIDTH'(FLUSH_TIMEOUT > 0 ? FLUSH_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, STROBE, WAIT, CAPTURE, PRESENT} state_t;

    state_t                   state_q, state_d;
    logic [31:0]              buf_q, buf_d, lane;
    logic [2:0]               cnt_q, cnt_d;
    logic [3:0]               lat_q;
    logic [TIMEOUT_WIDTH-1:0] idle_q;
    logic                     fifo_empty, timeout, accept, eol, cap, clr;
    logic                     strobe_d, busy_d, valid_d;
    logic [31:0]              data_d;
    logic [2:0]               count_d;
    logic                     unused_gpio;

    assign unused_gpio = ^console_gpio_output[31:9];
    assign fifo_empty  = console_gpio_output[8];
    assign accept      = word_valid & word_ready;
    assign eol         = NL_FLUSH && console_gpio_output[7:0] == 8'h0A;
    assign timeout     = FLUSH_TIMEOUT != 0 && cnt_q != 3'd0 && idle_q == IDLE_LAST;
    assign cap         = state_q == CAPTURE;
    assign clr         = state_q == PRESENT && accept;
    assign lane        = {24'h0, console_gpio_output[7:0]} << {cnt_q[1:0], 3'b000};
    assign buf_d       = clr ? 32'h0 : cap ? (buf_q | lane) : buf_q;
    assign cnt_d       = clr ? 3'd0 : cap ? cnt_q + 3'd1 : cnt_q;

    // next state: reads only while not presenting, so a stalled consumer backpressures into the FIFO
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !fifo_empty ? STROBE : timeout ? PRESENT : IDLE;
            STROBE:  state_d = READ_LATENCY <= 1 ? CAPTURE : WAIT;
            WAIT:    state_d = lat_q == LAT_LAST ? CAPTURE : WAIT;
            CAPTURE: state_d = (cnt_d == 3'd4 || eol) ? PRESENT : IDLE;
            PRESENT: state_d = accept ? IDLE : PRESENT;
            default: state_d = IDLE;
        endcase
    end

    // output values for the state being entered; the word snapshot is taken only on entry to PRESENT
    always_comb begin
        strobe_d = state_d == STROBE;
        busy_d   = state_d != IDLE;
        valid_d  = state_d == PRESENT;
        data_d   = state_d != PRESENT ? 32'h0 : state_q != PRESENT ? buf_d : word_data;
        count_d  = state_d != PRESENT ? 3'd0 : state_q != PRESENT ? cnt_d : word_count;
    end

    // state, packing buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            buf_q             <= '0;
            cnt_q             <= '0;
            console_rd_strobe <= 1'b0;
            busy              <= 1'b0;
            word_valid        <= 1'b0;
            word_data         <= '0;
            word_count        <= '0;
        end else begin
            state_q           <= state_d;
            buf_q             <= buf_d;
            cnt_q             <= cnt_d;
            console_rd_strobe <= strobe_d;
            busy              <= busy_d;
            word_valid        <= valid_d;
            word_data         <= data_d;
            word_count        <= count_d;
        end
    end

    // read-latency counter runs in WAIT; idle counter runs while a partial word sits in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q  <= '0;
            idle_q <= '0;
        end else begin
            lat_q  <= state_q == WAIT ? lat_q + 4'd1 : 4'd0;
            idle_q <= (state_q == IDLE && state_d == IDLE && cnt_q != 3'd0) ? idle_q + TIMEOUT_WIDTH'(1) : '0;
        end
    end
endmodule

// File: tb/tb_console_tx_packer.sv
// tb_console_tx_packer: directed checks of the console FIFO drain/packer against a GPIO FIFO model
module tb_console_tx_packer;
    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gpio[2] = '{32'h100, 32'h100};
    logic        strobe[2];
    logic [31:0] wdata[2];
    logic [2:0]  wcnt[2];
    logic        valid[2];
    logic        ready[2] = '{1'b1, 1'b1};
    logic        busy[2];

    int         pend[2] = '{0, 0};
    int         rd[2] = '{0, 0};
    int         wr[2] = '{0, 0};
    int         strobes[2] = '{0, 0};
    int         wide = 0;
    logic       prev[2] = '{1'b0, 1'b0};
    logic       emp[2] = '{1'b1, 1'b1};
    logic [7:0] dout[2] = '{8'h00, 8'h00};
    logic [7:0] pbyte[2];
    logic [7:0] mem[2][64];

    int checks = 0;
    int passed = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        console_tx_packer #(
            .READ_LATENCY (RL),
            .FLUSH_TIMEOUT(g == 0 ? 10 : 0),
            .TIMEOUT_WIDTH(16)
        ) u_dut (
            .clk                (clk),
            .rst_n              (rst_n),
            .console_gpio_output(gpio[g]),
            .console_rd_strobe  (strobe[g]),
            .word_data          (wdata[g]),
            .word_count         (wcnt[g]),
            .word_valid         (valid[g]),
            .word_ready         (ready[g]),
            .busy               (busy[g])
        );
    end

    // FIFO model: pops on strobe rise, shows garbage until the byte lands RL cycles later, then holds it
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (strobe[i] && prev[i]) wide++;
            if (strobe[i] && !prev[i]) begin
                strobes[i]++;
                pend[i] = RL;
                pbyte[i] = mem[i][rd[i]];
                rd[i]++;
                dout[i] = 8'hEE;
            end else if (pend[i] > 0) begin
                pend[i]--;
                if (pend[i] == 0) dout[i] = pbyte[i];
            end
            if (pend[i] == 0) emp[i] = rd[i] >= wr[i];
            prev[i] = strobe[i];
            gpio[i] = {23'h5A5A5, emp[i], dout[i]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input string s);
        for (int k = 0; k < s.len(); k++) begin
            mem[i][wr[i]] = s[k];
            wr[i]++;
        end
    endtask

    task automatic wait_valid(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid[i] && n < 300);
    endtask

    task automatic start_cycle();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, s, bad, highs;
        repeat (3) @(negedge clk);
        check("rst_strobe", 32'(strobe[0]), 0);
        check("rst_valid", 32'(valid[0]), 0);
        check("rst_data", wdata[0], 0);
        check("rst_count", 32'(wcnt[0]), 0);
        check("rst_busy", 32'(busy[0]), 0);
        rst_n = 1'b1;

        start_cycle();
        s = strobes[0];
        push(0, "ABCD");
        wait_valid(0, n);
        check("abcd_cycles", n, 21);
        check("abcd_data", wdata[0], 32'h44434241);
        check("abcd_count", 32'(wcnt[0]), 4);
        check("abcd_strobes", strobes[0] - s, 4);
        @(negedge clk);
        check("abcd_accepted", 32'(valid[0]), 0);
        check("abcd_count_clr", 32'(wcnt[0]), 0);

        start_cycle();
        push(0, "AB");
        wait_valid(0, n);
        check("ab_timeout_cycles", n, 21);
        check("ab_data", wdata[0], 32'h00004241);
        check("ab_count", 32'(wcnt[0]), 2);

        start_cycle();
        ready[0] = 1'b0;
        push(0, "012345");
        wait_valid(0, n);
        check("stall_cycles", n, 21);
        check("stall_data", wdata[0], 32'h33323130);
        check("stall_count", 32'(wcnt[0]), 4);
        s = strobes[0];
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!valid[0] || wdata[0] !== 32'h33323130 || wcnt[0] !== 3'd4) bad++;
        end
        check("stall_hold", bad, 0);
        check("stall_no_strobe", strobes[0] - s, 0);
        ready[0] = 1'b1;
        wait_valid(0, n);
        check("tail_cycles", n, 21);
        check("tail_data", wdata[0], 32'h00003534);
        check("tail_count", 32'(wcnt[0]), 2);

        start_cycle();
        push(0, "h\ni");
`ifdef CONSOLE_TX_PACKER_NL_FLUSH_EN
        wait_valid(0, n);
        check("nl_cycles", n, 11);
        check("nl_data", wdata[0], 32'h00000A68);
        check("nl_count", 32'(wcnt[0]), 2);
        wait_valid(0, n);
        check("nl_tail_cycles", n, 16);
        check("nl_tail_data", wdata[0], 32'h00000069);
        check("nl_tail_count", 32'(wcnt[0]), 1);
`else
        wait_valid(0, n);
        check("nl_cycles", n, 26);
        check("nl_data", wdata[0], 32'h00690A68);
        check("nl_count", 32'(wcnt[0]), 3);
`endif

        start_cycle();
        push(0, "QR");
        repeat (7) @(posedge clk);
        #2;
        check("wait_busy", 32'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy[0]), 0);
        check("arst_strobe", 32'(strobe[0]), 0);
        check("arst_valid", 32'(valid[0]), 0);
        check("arst_data", wdata[0], 0);
        check("arst_count", 32'(wcnt[0]), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_cycle();
        push(0, "S");
        wait_valid(0, n);
        check("post_rst_cycles", n, 16);
        check("post_rst_data", wdata[0], 32'h00000053);
        check("post_rst_count", 32'(wcnt[0]), 1);

        start_cycle();
        check("empty_no_strobe", strobes[1], 0);
        push(1, "Z");
        highs = 0;
        repeat (5000) begin
            @(negedge clk);
            if (valid[1]) highs++;
        end
        check("nto_valid", highs, 0);
        check("nto_busy", 32'(busy[1]), 0);
        check("nto_strobes", strobes[1], 1);
        check("strobe_width", wide, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/console_tx_packer.md
Name: console_tx_packer

Overview:
- Automatic drain stage for the console output FIFO. It sits downstream of console_io's GPIO-facing output word, on the fabric side in place of the PS software poll loop.
- It watches the FIFO-empty flag and generates read strobes on the GPIO read-request line. It then captures each returned byte and packs up to 4 characters into a 32-bit word with a valid/ready handshake to the PS-side consumer.
- This cuts PS reads per character from ~3 GPIO accesses to 1/4 word.

Parameters:
- READ_LATENCY, 3, clk cycles from strobe rising edge to a valid byte on console_gpio_output[7:0] (edge detect + FIFO read + output register). Legal range 1..15.
- FLUSH_TIMEOUT, 1000, idle clk cycles with a partial word before a forced flush. 0 = never time out.
- TIMEOUT_WIDTH, 16, width of the idle timeout counter. Must hold FLUSH_TIMEOUT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- console_gpio_output  input  32  from console_io: bit8 = output FIFO empty, [7:0] = read data, rest ignored
- console_rd_strobe  output  1  drives console_io read-request GPIO bit (bit9). Level signal; consumer acts on its rising edge.
- word_data  output  32  packed chars; first char in [7:0], second in [15:8], etc.; unused bytes zero
- word_count  output  3  number of valid chars in word_data, 1..4 while word_valid
- word_valid  output  1  packed word available
- word_ready  input  1  consumer accepts word when word_valid & word_ready
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, console_rd_strobe=0, word_data=0, word_count=0, word_valid=0, busy=0, internal buffer/count/timers cleared. Reset mid-read abandons the in-flight byte; the FIFO has already popped it, and the loss is accepted.
- All outputs are registered.
- States: IDLE, STROBE, WAIT, CAPTURE, PRESENT.
- IDLE:
  - if console_gpio_output[8]==0 → STROBE.
  - else if buffered count>0 and FLUSH_TIMEOUT!=0 and idle counter reaches FLUSH_TIMEOUT-1 → PRESENT.
  - The idle counter increments each IDLE cycle while count>0. It clears on leaving IDLE and on count==0.
- STROBE: console_rd_strobe=1 for exactly 1 cycle → WAIT.
- WAIT:
  - console_rd_strobe=0; the low phase guarantees a fresh rising edge for the next read.
  - Latency counter runs READ_LATENCY-1 cycles after STROBE, so the strobe rising edge to the CAPTURE sample is READ_LATENCY cycles → CAPTURE.
- CAPTURE:
  - Store console_gpio_output[7:0] into byte lane [count], then count+1.
  - If count becomes 4 → PRESENT, else → IDLE.
  - The empty flag is not sampled in CAPTURE; IDLE re-samples it on the following cycle, and that value is fully settled after the read.
- PRESENT:
  - word_data/word_count load from the buffer on entry; word_valid=1 held stable until word_valid&word_ready.
  - On the accepting edge: word_valid=0, buffer and count cleared, → IDLE.
  - No FIFO reads occur in PRESENT, which provides backpressure; the console_io FIFO absorbs chars.
- word_ready high while word_valid=0 has no effect.
- Max throughput: 1 char per (READ_LATENCY+2) cycles.
- FIFO empty during the whole run: strobe never asserts.

Optional Feature:
- Macro: CONSOLE_TX_PACKER_NL_FLUSH_EN.
- Defined: in CAPTURE, a captured byte 8'h0A forces → PRESENT regardless of count, so each line is delivered promptly.
- Undefined: newline is treated as an ordinary char; flush occurs only on count==4 or timeout.

Test Plan:
- FIFO model holds "ABCD" (41,42,43,44), READ_LATENCY=3, word_ready=1 → 4 single-cycle strobe pulses, each followed by ≥1 low cycle. Then word_valid=1, word_data=32'h44434241, word_count=4, accepted next cycle.
- FIFO holds "AB" then stays empty, FLUSH_TIMEOUT=10 → exactly 10 IDLE cycles after second capture, then word_valid with word_data=32'h00004241, word_count=2.
- 6 chars "012345", word_ready=0 for 20 cycles → first word 32'h33323130 held stable; no strobe during stall. After ready: second word 32'h00003534 only after timeout.
- NL_FLUSH_EN defined, FIFO "h\ni" → word 32'h00000A68 count 2, then 32'h00000069 count 1 after timeout. Undefined: single word 32'h00690A68 count 3 after timeout.
- Assert rst_n=0 asynchronously during WAIT → all outputs 0 immediately (same cycle). After release, state IDLE, buffer empty, next word starts at lane 0.
- FLUSH_TIMEOUT=0, one char "Z" then empty for 5000 cycles → word_valid stays 0, busy stays 0 after capture.
